// File: rtl/hw_stack.sv
// LIFO stack engine: owns the occupancy pointer, assembles half-word pushes and
// returns registered POP/PEEK results from a synchronous-read RAM.
module hw_stack #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            ce,
    input  logic                            op_valid,
    input  logic [2:0]                      op,
    input  logic [DATA_WIDTH-1:0]           push_data,
    input  logic [DATA_WIDTH/2-1:0]         half_data,
    input  logic                            err_clear,
    output logic                            op_ready,
    output logic                            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            full,
    output logic                            empty,
    output logic                            low_pending,
    output logic                            overflow_err,
    output logic                            underflow_err
);

    localparam int unsigned HALF_WIDTH = DATA_WIDTH / 2;
    localparam int unsigned PTR_WIDTH  = $clog2(DEPTH + 1);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OpNop      = 3'd0,
        OpPush     = 3'd1,
        OpPop      = 3'd2,
        OpPeek     = 3'd3,
        OpPushLow  = 3'd4,
        OpPushHigh = 3'd5,
        OpClear    = 3'd6,
        OpRsvd     = 3'd7
    } op_e;

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    state_e                  state_q, state_d;
    logic [PTR_WIDTH-1:0]    count_q, count_d;
    logic [HALF_WIDTH-1:0]   low_hold_q, low_hold_d;
    logic                    low_pending_q, low_pending_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;

    logic                    accept;
    logic                    push_req;
    logic [DATA_WIDTH-1:0]   push_word;
    logic                    ram_we;
    logic                    ram_re;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [ADDR_WIDTH-1:0]   ram_raddr;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign full        = (count_q == PTR_WIDTH'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign op_ready    = (state_q == StIdle);
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign low_pending = low_pending_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

    assign accept    = ce & op_valid & op_ready;
    assign ram_waddr = ADDR_WIDTH'(count_q);
    assign ram_raddr = ADDR_WIDTH'(count_q - PTR_WIDTH'(1));

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        low_hold_d    = low_hold_q;
        low_pending_d = low_pending_q;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        // err_clear loses to a same-edge error event, which is applied below.
        overflow_d    = err_clear ? 1'b0 : overflow_q;
        underflow_d   = err_clear ? 1'b0 : underflow_q;
        push_req      = 1'b0;
        push_word     = push_data;
        ram_we        = 1'b0;
        ram_re        = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (op)
                        OpPush: begin
                            push_req = 1'b1;
                        end
                        OpPushLow: begin
                            low_hold_d    = half_data;
                            low_pending_d = 1'b1;
                        end
                        OpPushHigh: begin
                            push_req      = 1'b1;
                            push_word     = {half_data, low_pending_q ? low_hold_q : '0};
                            low_pending_d = 1'b0;
                        end
                        OpPop, OpPeek: begin
                            if (empty) begin
                                underflow_d = 1'b1;
                            end else begin
                                ram_re  = 1'b1;
                                state_d = StRead;
                                if (op == OpPop) begin
                                    count_d = count_q - PTR_WIDTH'(1);
                                end
                            end
                        end
                        OpClear: begin
                            count_d       = '0;
                            low_pending_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            StRead: begin
                state_d    = StIdle;
                rd_valid_d = 1'b1;
                rd_data_d  = ram_rdata;
            end
            default: state_d = StIdle;
        endcase

        if (push_req) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                ram_we  = 1'b1;
                count_d = count_q + PTR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            count_q       <= '0;
            low_hold_q    <= '0;
            low_pending_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            low_hold_q    <= low_hold_d;
            low_pending_q <= low_pending_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= push_word;
        end
        if (ram_re) begin
            ram_rdata <= mem[ram_raddr];
        end
    end

endmodule

// File: tb/tb_hw_stack.sv
// Scoreboard bench for hw_stack: default 12x64 instance plus a 16x5 instance.
module tb_hw_stack;

    localparam logic [2:0] OP_PUSH = 3'd1, OP_POP = 3'd2, OP_PEEK = 3'd3;
    localparam logic [2:0] OP_PLOW = 3'd4, OP_PHIGH = 3'd5, OP_CLEAR = 3'd6;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic        op_valid1 = 1'b0, op_valid2 = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] push_data = '0;
    logic [7:0]  half_data = '0;
    logic        err_clear = 1'b0;

    logic        op_ready1, rd_valid1, full1, empty1, low_pending1, ovf1, unf1;
    logic [11:0] rd_data1;
    logic [6:0]  count1;
    logic        op_ready2, rd_valid2, full2, empty2, low_pending2, ovf2, unf2;
    logic [15:0] rd_data2;
    logic [2:0]  count2;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q1[$];
    exp_t q2[$];

    hw_stack #(.DATA_WIDTH(12), .DEPTH(64)) dut1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .op_valid(op_valid1), .op(op),
        .push_data(push_data[11:0]), .half_data(half_data[5:0]), .err_clear(err_clear),
        .op_ready(op_ready1), .rd_valid(rd_valid1), .rd_data(rd_data1), .count(count1),
        .full(full1), .empty(empty1), .low_pending(low_pending1),
        .overflow_err(ovf1), .underflow_err(unf1)
    );

    hw_stack #(.DATA_WIDTH(16), .DEPTH(5)) dut2 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .op_valid(op_valid2), .op(op),
        .push_data(push_data), .half_data(half_data), .err_clear(err_clear),
        .op_ready(op_ready2), .rd_valid(rd_valid2), .rd_data(rd_data2), .count(count2),
        .full(full2), .empty(empty2), .low_pending(low_pending2),
        .overflow_err(ovf2), .underflow_err(unf2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: every rd_valid pulse must match the oldest expected read.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rd_valid1) begin
            if (q1.size() == 0) begin
                chk("rd_valid1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("rd_data1", {20'd0, rd_data1}, {16'd0, e.data});
                chk("rd_latency1", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rd_valid2) begin
            if (q2.size() == 0) begin
                chk("rd_valid2_unexpected", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("rd_data2", {16'd0, rd_data2}, {16'd0, e.data});
                chk("rd_latency2", cyc, e.cyc);
            end
        end
    end

    // Called at #1 after a posedge; returns #1 after the accepting edge.
    task automatic issue(input int sel, input logic [2:0] o, input logic [15:0] d,
                         input logic [7:0] h, input bit exp_rd, input logic [15:0] exp_data);
        int n = 0;
        while (!(sel == 1 ? op_ready1 : op_ready2) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 20) chk("op_ready_timeout", 32'd0, 32'd1);
        op        = o;
        push_data = d;
        half_data = h;
        if (exp_rd) begin
            if (sel == 1) q1.push_back('{exp_data, cyc + 2});
            else          q2.push_back('{exp_data, cyc + 2});
        end
        if (sel == 1) op_valid1 = 1'b1;
        else          op_valid2 = 1'b1;
        @(posedge clk);
        #1;
        op_valid1 = 1'b0;
        op_valid2 = 1'b0;
        op        = 3'd0;
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        #12;
        chk("rst_count", count1, 0);
        chk("rst_empty", empty1, 1);
        chk("rst_full", full1, 0);
        chk("rst_op_ready", op_ready1, 1);
        chk("rst_rd_valid", rd_valid1, 0);
        chk("rst_rd_data", rd_data1, 0);
        chk("rst_low_pending", low_pending1, 0);
        chk("rst_errs", {ovf1, unf1}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic LIFO order and READ-cycle handshake.
        issue(1, OP_PUSH, 16'h123, 0, 0, 0);
        issue(1, OP_PUSH, 16'h456, 0, 0, 0);
        chk("count_after_push2", count1, 2);
        issue(1, OP_POP, 0, 0, 1, 16'h456);
        chk("op_ready_in_read_a", op_ready1, 0);
        chk("count_after_pop1", count1, 1);
        issue(1, OP_POP, 0, 0, 1, 16'h123);
        chk("op_ready_in_read_b", op_ready1, 0);
        chk("count_after_pop2", count1, 0);
        chk("empty_after_pops", empty1, 1);

        // Half-word assembly.
        issue(1, OP_PLOW, 0, 8'h2A, 0, 0);
        chk("low_pending_set", low_pending1, 1);
        chk("count_after_plow", count1, 0);
        issue(1, OP_PHIGH, 0, 8'h15, 0, 0);
        chk("low_pending_clr", low_pending1, 0);
        chk("count_after_phigh", count1, 1);
        issue(1, OP_PEEK, 0, 0, 1, 16'h56A);
        chk("count_after_peek", count1, 1);
        issue(1, OP_PHIGH, 0, 8'h3F, 0, 0);
        issue(1, OP_PEEK, 0, 0, 1, 16'hFC0);
        issue(1, OP_CLEAR, 0, 0, 0, 0);
        chk("count_after_clear", count1, 0);

        // Fill, overflow, pop the top.
        for (int i = 0; i < 64; i++) issue(1, OP_PUSH, 16'(i), 0, 0, 0);
        chk("count_full", count1, 64);
        chk("full_flag", full1, 1);
        issue(1, OP_PUSH, 16'hFFF, 0, 0, 0);
        chk("overflow_set", ovf1, 1);
        chk("count_overflow", count1, 64);
        issue(1, OP_POP, 0, 0, 1, 16'h03F);
        chk("full_after_pop", full1, 0);
        issue(1, OP_CLEAR, 0, 0, 0, 0);
        chk("overflow_kept_by_clear", ovf1, 1);
        pulse_err_clear();
        chk("overflow_cleared", ovf1, 0);

        // Underflow and err_clear priority.
        issue(1, OP_POP, 0, 0, 0, 0);
        chk("underflow_set", unf1, 1);
        chk("op_ready_after_unf", op_ready1, 1);
        chk("count_after_unf", count1, 0);
        err_clear = 1'b1;
        issue(1, OP_POP, 0, 0, 0, 0);
        err_clear = 1'b0;
        chk("underflow_wins_clear", unf1, 1);
        pulse_err_clear();
        chk("underflow_cleared", unf1, 0);

        // Clock enable gating.
        ce        = 1'b0;
        op        = OP_PUSH;
        push_data = 16'h777;
        op_valid1 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("count_ce_low", count1, 0);
        ce = 1'b1;
        @(posedge clk);
        #1;
        op_valid1 = 1'b0;
        chk("count_ce_one", count1, 1);
        issue(1, OP_PEEK, 0, 0, 1, 16'h777);

        // Reset during READ aborts the read.
        issue(1, OP_POP, 0, 0, 0, 0);
        chk("op_ready_before_abort", op_ready1, 0);
        reset_n = 1'b0;
        #1;
        chk("abort_op_ready", op_ready1, 1);
        chk("abort_rd_valid", rd_valid1, 0);
        chk("abort_rd_data", rd_data1, 0);
        chk("abort_count", count1, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("count_after_abort", count1, 0);

        // Second parameter set: 16-bit words, depth 5.
        for (int i = 0; i < 4; i++) issue(2, OP_PUSH, 16'h1000 + 16'(i), 0, 0, 0);
        chk("p2_count4", count2, 4);
        chk("p2_not_full", full2, 0);
        issue(2, OP_PLOW, 0, 8'hCD, 0, 0);
        chk("p2_low_pending", low_pending2, 1);
        issue(2, OP_PHIGH, 0, 8'hAB, 0, 0);
        chk("p2_count5", count2, 5);
        chk("p2_full", full2, 1);
        issue(2, OP_PEEK, 0, 0, 1, 16'hABCD);
        issue(2, OP_PUSH, 16'hEEEE, 0, 0, 0);
        chk("p2_overflow", ovf2, 1);
        issue(2, OP_POP, 0, 0, 1, 16'hABCD);
        issue(2, OP_POP, 0, 0, 1, 16'h1003);

        repeat (4) @(posedge clk);
        #1;
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hw_stack.md
Name: hw_stack

Overview:
- Parametrised hardware LIFO stack engine for the core's user stack. Replaces the bare stack memory plus external pointer.
- Owns the pointer, full/empty tracking and overflow/underflow detection.
- Assembles full words from two half-word pushes (PUSH_LOW / PUSH_HIGH), matching the ISA's 6-bit immediate pushes.
- Sits between the core datapath (EXEC state) and an internal synchronous-read RAM. Registered pop/peek data comes back over a simple valid/ready handshake.

Parameters:
DATA_WIDTH, 12, stack word width in bits; must be even.
DEPTH, 64, number of entries; any value >= 2, not required to be a power of two.
HALF_WIDTH, DATA_WIDTH/2, derived local parameter; width of half-word pushes.
PTR_WIDTH, $clog2(DEPTH+1), derived local parameter; width of the occupancy counter.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
ce  input  1  clock enable; ops are sampled only when ce=1
op_valid  input  1  request strobe
op  input  3  0=NOP 1=PUSH 2=POP 3=PEEK 4=PUSH_LOW 5=PUSH_HIGH 6=CLEAR 7=reserved (treated as NOP)
push_data  input  DATA_WIDTH  full word for PUSH
half_data  input  HALF_WIDTH  half word for PUSH_LOW / PUSH_HIGH
err_clear  input  1  clears sticky error flags
op_ready  output  1  block can accept an op this cycle
rd_valid  output  1  one-cycle pulse; rd_data holds a POP/PEEK result
rd_data  output  DATA_WIDTH  registered top-of-stack result
count  output  PTR_WIDTH  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
low_pending  output  1  a PUSH_LOW half is held, awaiting PUSH_HIGH
overflow_err  output  1  sticky; a push was attempted while full
underflow_err  output  1  sticky; a POP/PEEK was attempted while empty

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, count=0, low_hold=0, low_pending=0.
  - rd_valid=0, rd_data=0, both error flags 0, op_ready=1.
  - RAM contents are not reset.
- An op is accepted on the rising edge where ce & op_valid & op_ready are all 1. Otherwise it is ignored with no side effects.
- FSM has two states, IDLE and READ:
  - op_ready = (state==IDLE).
  - READ lasts exactly one clk cycle, independent of ce.
- PUSH:
  - If not full: RAM[count] <= push_data, count+1.
  - If full: no write, count unchanged, overflow_err <= 1.
  - Does not modify low_hold or low_pending.
- PUSH_LOW: low_hold <= half_data, low_pending <= 1. No RAM write, count unchanged. A second PUSH_LOW overwrites low_hold.
- PUSH_HIGH:
  - Word = {half_data, low_pending ? low_hold : 0}.
  - Pushed with the same full/overflow rules as PUSH.
  - low_pending <= 0 in all cases, including overflow.
- POP / PEEK:
  - If empty: underflow_err <= 1, stay in IDLE, no rd_valid, count unchanged.
  - Otherwise: RAM read address count-1 is presented at accept edge E0, state <= READ.
  - At edge E1, rd_data <= RAM output and rd_valid <= 1 for exactly one cycle; state <= IDLE.
  - Latency is 1 cycle from accept to rd_valid; maximum throughput is one read every 2 cycles.
  - POP decrements count at E0; PEEK leaves count unchanged.
  - full and empty reflect the new count from E0.
- CLEAR: count <= 0, low_pending <= 0. Error flags are unaffected.
- err_clear: clears both error flags on any edge, regardless of ce. If an error event and err_clear occur on the same edge, the flag ends up set.
- rd_data holds its last value between reads.
- full, empty and count are combinational from registered count.
- Reset asserted during READ:
  - Returns to IDLE immediately.
  - No rd_valid is ever produced for the aborted read.

Test Plan:
- Reset, then PUSH 0x123, 0x456, then POP, POP -> rd_data 0x456 then 0x123, each rd_valid one cycle after accept; op_ready low during each READ cycle; final count=0, empty=1.
- PUSH_LOW 0x2A, then PUSH_HIGH 0x15 -> PEEK returns 0x56A; count=1; low_pending goes 1 then 0. PUSH_HIGH 0x3F with no pending low half -> top of stack = 0xFC0.
- Fill to DEPTH=64 with values 0..63 -> full=1; one more PUSH 0xFFF -> overflow_err=1, count stays 64, POP returns 63.
- POP on empty stack -> underflow_err=1, rd_valid never asserts, count stays 0. err_clear together with a second empty POP on the same edge -> flag stays 1; err_clear alone -> flag 0.
- ce=0 with op_valid=1 and op=PUSH for 10 cycles -> count unchanged. Raise ce for one cycle -> exactly one push, count=1.
- Accept a POP, then assert reset_n=0 during the READ cycle -> outputs at reset values immediately, no rd_valid pulse after reset release, count=0.
- Parameter sweep with DATA_WIDTH=16 and DEPTH=5 -> full at count=5; half pushes 0xCD then 0xAB give 0xABCD.
